mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares one single-port 16-bit BRAM/SDRAM-style memory port between the fx68k CPU bus and the ESP32 SPI loader (spi_ram_btn byte interface).
- Generates the CPU's DTACKn with a programmable number of wait states.
- Executes queued SPI byte reads/writes between CPU cycles, with round-robin fairness so neither requester starves.
- Sits between the CPU/SPI slave and the ROM/RAM instance, replacing the hard-tied dtack_n and the separate SPI write port.

Parameters:
c_mem_aw, 15, memory word-address width; mem_addr = cpu_addr[c_mem_aw:1] or spi_addr[c_mem_aw:1]
c_spi_aw, 24, SPI byte-address width; upper bits beyond c_mem_aw+1 ignored
c_wait, 1, extra memory cycles before data capture (0..15); memory read latency is 1 cycle

Ports:
clk  in  1  system clock (clk_cpu domain)
reset  in  1  asynchronous, active-high reset
cpu_sel  in  1  external decode: current CPU address targets this memory
cpu_as_n  in  1  CPU address strobe
cpu_rw  in  1  1=read, 0=write
cpu_uds_n  in  1  upper byte strobe
cpu_lds_n  in  1  lower byte strobe
cpu_addr  in  23  CPU address [23:1]
cpu_wdata  in  16  CPU write data
cpu_rdata  out  16  registered read data to CPU
cpu_dtack_n  out  1  data transfer acknowledge
spi_wr  in  1  single-cycle SPI write request
spi_rd  in  1  single-cycle SPI read request
spi_addr  in  c_spi_aw  SPI byte address
spi_wdata  in  8  SPI write byte
spi_rdata  out  8  SPI read byte, valid with spi_ack
spi_ack  out  1  one-cycle pulse: SPI access completed
spi_busy  out  1  SPI request pending or in progress
spi_overrun  out  1  one-cycle pulse: request dropped while busy
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_ub  out  1  upper byte lane enable
mem_lb  out  1  lower byte lane enable
mem_addr  out  c_mem_aw  word address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, 1-cycle latency

Behaviour:
- Reset (asynchronous): state IDLE, cpu_dtack_n=1, cpu_rdata=0, spi_rdata=0, spi_ack=0, spi_busy=0, spi_overrun=0, all mem_* outputs 0, pending cleared, last_grant=SPI.
- SPI request capture:
  - spi_wr or spi_rd while !spi_busy latches addr, data and direction; spi_busy goes 1 on the next cycle.
  - Any request while busy is dropped and pulses spi_overrun.
  - spi_wr and spi_rd asserted together count as a write.
- CPU request: cpu_req = !cpu_as_n && cpu_sel && (!cpu_uds_n || !cpu_lds_n).
- States:
  - IDLE:
    - If spi_pending and (last_grant==CPU or !cpu_req), go to SPI_ACC.
    - Otherwise, if cpu_req, go to CPU_ACC.
  - CPU_ACC (length c_wait+1 cycles):
    - mem_en=1 and address/lanes driven every cycle.
    - mem_we=1 in the first cycle only, when !cpu_rw.
    - On the last cycle, cpu_rdata is captured from mem_rdata (reads only); then cpu_dtack_n=0 on the next cycle, last_grant=CPU, go to CPU_HOLD.
    - If cpu_as_n goes high mid-access: abort to IDLE, no DTACK. A write already issued stands.
  - CPU_HOLD:
    - cpu_dtack_n stays 0 and cpu_rdata stays stable while cpu_as_n=0.
    - The cycle after cpu_as_n=1: cpu_dtack_n=1 and go to IDLE.
    - SPI is never granted here.
  - SPI_ACC (c_wait+1 cycles), same timing as CPU_ACC:
    - Byte lane: spi_addr[0]=0 → ub (big-endian), 1 → lb.
    - mem_wdata = {spi_wdata, spi_wdata}.
    - At the end: spi_rdata = selected byte, spi_ack pulses, spi_busy clears, last_grant=SPI, go to IDLE.
- Latency:
  - CPU read with c_wait=1: as_n low at cycle T (IDLE) → CPU_ACC T+1..T+2 → dtack_n low at T+3.
  - Worst case when an SPI access is ahead: c_wait+2 additional cycles.
- mem_* outputs are 0 in IDLE and CPU_HOLD. mem_addr is truncated to c_mem_aw bits.

Decomposition:
- Shared package mem_bus_pkg: state encoding (IDLE, CPU_ACC, CPU_HOLD, SPI_ACC), grant enum, c_wait width constant.
- One natural sub-module: spi_req_latch (capture, busy, overrun logic).

Test Plan:
1. Reset then CPU read, cpu_addr=0x000010, mem word 0x4E71, c_wait=1: dtack_n low exactly 3 cycles after as_n falls, cpu_rdata=0x4E71, dtack_n high one cycle after as_n rises.
2. CPU byte write: lds_n=0, uds_n=1, wdata=0x00AA → one mem_we pulse with mem_lb=1, mem_ub=0, mem_addr=0x0008.
3. spi_wr addr=0x000003 data=0x5A while CPU idle → mem_lb=1, mem_wdata=0x5A5A, spi_ack after c_wait+2 cycles, spi_busy 1→0.
4. CPU request and SPI request in the same cycle with last_grant=CPU → SPI served first. CPU dtack delayed by c_wait+2 cycles; the following simultaneous pair is served CPU first.
5. Second spi_rd while busy → spi_overrun pulses once, only one spi_ack. Assert reset mid-CPU_ACC → all outputs return to reset values immediately, with no mem_we afterwards.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU/SPI memory-port arbiter: FSM states, grant owner,
// wait-counter width and the big-endian byte-lane helpers.
package mem_bus_pkg;

   localparam int unsigned C_WAIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CPU_ACC,
      ST_CPU_HOLD,
      ST_SPI_ACC
   } state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_SPI
   } grant_t;

   // Even byte addresses live in the upper lane (68k big-endian layout).
   function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic odd);
      return odd ? word[7:0] : word[15:8];
   endfunction

   function automatic logic [1:0] byte_lanes(input logic odd);
      return odd ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/spi_req_latch.sv
// Holds one outstanding SPI byte request; requests arriving while one is
// outstanding are dropped and flagged with a single-cycle overrun pulse.
module spi_req_latch
   import mem_bus_pkg::*;
#(
   parameter int unsigned c_spi_aw = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_wr,
   input  logic                i_rd,
   input  logic [c_spi_aw-1:0] i_addr,
   input  logic [7:0]          i_wdata,
   input  logic                i_done,
   output logic                o_busy,
   output logic                o_overrun,
   output logic                o_we,
   output logic [c_spi_aw-1:0] o_addr,
   output logic [7:0]          o_wdata
);

   logic                w_req;
   logic                r_busy;
   logic                r_overrun;
   logic                r_we;
   logic [c_spi_aw-1:0] r_addr;
   logic [7:0]          r_wdata;

   assign w_req = i_wr | i_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_overrun <= w_req & r_busy;
         if (!r_busy && w_req) begin
            r_busy  <= 1'b1;
            r_we    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
         end else if (i_done) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_overrun = r_overrun;
   assign o_we      = r_we;
   assign o_addr    = r_addr;
   assign o_wdata   = r_wdata;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 16-bit single-port memory between the 68k bus and the SPI loader,
// generating DTACKn with programmable wait states and round-robin arbitration.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned c_mem_aw = 15,
   parameter int unsigned c_spi_aw = 24,
   parameter int unsigned c_wait   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_sel,
   input  logic                cpu_as_n,
   input  logic                cpu_rw,
   input  logic                cpu_uds_n,
   input  logic                cpu_lds_n,
   input  logic [23:1]         cpu_addr,
   input  logic [15:0]         cpu_wdata,
   output logic [15:0]         cpu_rdata,
   output logic                cpu_dtack_n,
   input  logic                spi_wr,
   input  logic                spi_rd,
   input  logic [c_spi_aw-1:0] spi_addr,
   input  logic [7:0]          spi_wdata,
   output logic [7:0]          spi_rdata,
   output logic                spi_ack,
   output logic                spi_busy,
   output logic                spi_overrun,
   output logic                mem_en,
   output logic                mem_we,
   output logic                mem_ub,
   output logic                mem_lb,
   output logic [c_mem_aw-1:0] mem_addr,
   output logic [15:0]         mem_wdata,
   input  logic [15:0]         mem_rdata
);

   localparam logic [C_WAIT_W-1:0] C_LAST = C_WAIT_W'(c_wait);

   state_t              r_state;
   grant_t              r_last;
   logic [C_WAIT_W-1:0] r_cnt;
   logic                r_dtack_n;
   logic [15:0]         r_cpu_rdata;
   logic [7:0]          r_spi_rdata;
   logic                r_spi_ack;
   logic                r_mem_en;
   logic                r_mem_we;
   logic                r_mem_ub;
   logic                r_mem_lb;
   logic [c_mem_aw-1:0] r_mem_addr;
   logic [15:0]         r_mem_wdata;

   logic                w_cpu_req;
   logic                w_spi_busy;
   logic                w_spi_we;
   logic [c_spi_aw-1:0] w_spi_addr;
   logic [7:0]          w_spi_wdata;
   logic                w_spi_done;
   logic                w_acc_last;
   logic                w_unused;

   assign w_cpu_req  = !cpu_as_n && cpu_sel && (!cpu_uds_n || !cpu_lds_n);
   assign w_acc_last = (r_cnt == C_LAST);
   assign w_spi_done = (r_state == ST_SPI_ACC) && w_acc_last;
   assign w_unused   = &{1'b0, cpu_addr, w_spi_addr};

   spi_req_latch #(
      .c_spi_aw (c_spi_aw)
   ) u_spi_req (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (spi_wr),
      .i_rd      (spi_rd),
      .i_addr    (spi_addr),
      .i_wdata   (spi_wdata),
      .i_done    (w_spi_done),
      .o_busy    (w_spi_busy),
      .o_overrun (spi_overrun),
      .o_we      (w_spi_we),
      .o_addr    (w_spi_addr),
      .o_wdata   (w_spi_wdata)
   );

   // Memory strobes are registered on entry to an access state and cleared on
   // exit, so they are high exactly while the FSM sits in CPU_ACC or SPI_ACC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last      <= GNT_SPI;
         r_cnt       <= '0;
         r_dtack_n   <= 1'b1;
         r_cpu_rdata <= '0;
         r_spi_rdata <= '0;
         r_spi_ack   <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_ub    <= 1'b0;
         r_mem_lb    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_spi_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_spi_busy && (r_last == GNT_CPU || !w_cpu_req)) begin
                  r_state                <= ST_SPI_ACC;
                  r_mem_en               <= 1'b1;
                  r_mem_we               <= w_spi_we;
                  {r_mem_ub, r_mem_lb}   <= byte_lanes(w_spi_addr[0]);
                  r_mem_addr             <= w_spi_addr[c_mem_aw:1];
                  r_mem_wdata            <= {w_spi_wdata, w_spi_wdata};
               end else if (w_cpu_req) begin
                  r_state     <= ST_CPU_ACC;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= !cpu_rw;
                  r_mem_ub    <= !cpu_uds_n;
                  r_mem_lb    <= !cpu_lds_n;
                  r_mem_addr  <= cpu_addr[c_mem_aw:1];
                  r_mem_wdata <= cpu_wdata;
               end
            end

            ST_CPU_ACC: begin
               r_mem_we <= 1'b0;
               if (cpu_as_n || w_acc_last) begin
                  r_mem_en    <= 1'b0;
                  r_mem_ub    <= 1'b0;
                  r_mem_lb    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
               end
               if (cpu_as_n) begin
                  r_state <= ST_IDLE;
               end else if (w_acc_last) begin
                  if (cpu_rw) begin
                     r_cpu_rdata <= mem_rdata;
                  end
                  r_dtack_n <= 1'b0;
                  r_last    <= GNT_CPU;
                  r_state   <= ST_CPU_HOLD;
               end else begin
                  r_cnt <= r_cnt + C_WAIT_W'(1);
               end
            end

            ST_CPU_HOLD: begin
               if (cpu_as_n) begin
                  r_dtack_n <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end

            ST_SPI_ACC: begin
               r_mem_we <= 1'b0;
               if (w_acc_last) begin
                  r_spi_rdata <= sel_byte(mem_rdata, w_spi_addr[0]);
                  r_spi_ack   <= 1'b1;
                  r_last      <= GNT_SPI;
                  r_state     <= ST_IDLE;
                  r_mem_en    <= 1'b0;
                  r_mem_ub    <= 1'b0;
                  r_mem_lb    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
               end else begin
                  r_cnt <= r_cnt + C_WAIT_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata   = r_cpu_rdata;
   assign cpu_dtack_n = r_dtack_n;
   assign spi_rdata   = r_spi_rdata;
   assign spi_ack     = r_spi_ack;
   assign spi_busy    = w_spi_busy;
   assign mem_en      = r_mem_en;
   assign mem_we      = r_mem_we;
   assign mem_ub      = r_mem_ub;
   assign mem_lb      = r_mem_lb;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

endmodule
